bcd_to_bin: RTL and testbench

- Clocked converter from two-digit packed BCD (tens nibble, ones nibble) to unsigned binary.
- Produces a narrow 4-bit result for the ALU operand path and a full 7-bit result for wider consumers.
- Flags non-BCD input and results that do not fit in 4 bits.
- Used on the ALU input side, where operands arrive as BCD and are needed in binary.

---
 rtl/bcd_to_bin.sv | 107 ++++++++++
 tb/tb_bcd_to_bin.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// Two-digit packed BCD to binary converter for the ALU operand path.
// Produces a 4-bit saturated result and a 7-bit full result, plus invalid and overflow flags.
module bcd_to_bin #(
    parameter int BCD_W  = 8,
    parameter int BIN_W  = 4,
    parameter int FULL_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BCD_W-1:0]  BCD,
    output logic [BIN_W-1:0]  bin,
    output logic [FULL_W-1:0] bin_full,
    output logic              busy,
    output logic              done,
    output logic              invalid,
    output logic              overflow
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state;
    logic [BCD_W-1:0]    opnd;
    logic [BIN_W-1:0]    res_bin;
    logic [FULL_W-1:0]   res_full;
    logic                res_inv;
    logic                res_ovf;

    logic [3:0]          t;
    logic [3:0]          o;
    logic [FULL_W-1:0]   v;
    logic [BIN_W-1:0]    calc_bin;
    logic [FULL_W-1:0]   calc_full;
    logic                calc_inv;
    logic                calc_ovf;

    // tens*10 formed as tens*8 + tens*2 so no multiplier is inferred
    always_comb begin
        t         = opnd[BCD_W-1:4];
        o         = opnd[3:0];
        v         = (FULL_W'(t) << 3) + (FULL_W'(t) << 1) + FULL_W'(o);
        calc_bin  = '0;
        calc_full = '0;
        calc_inv  = 1'b0;
        calc_ovf  = 1'b0;
        if (t > 4'd9 || o > 4'd9) begin
            calc_inv = 1'b1;
        end else begin
            calc_full = v;
            if (v > FULL_W'((1 << BIN_W) - 1)) begin
                calc_bin = '1;
                calc_ovf = 1'b1;
            end else begin
                calc_bin = v[BIN_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            opnd     <= '0;
            res_bin  <= '0;
            res_full <= '0;
            res_inv  <= 1'b0;
            res_ovf  <= 1'b0;
            bin      <= '0;
            bin_full <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            invalid  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opnd  <= BCD;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    res_bin  <= calc_bin;
                    res_full <= calc_full;
                    res_inv  <= calc_inv;
                    res_ovf  <= calc_ovf;
                    state    <= DONE;
                end
                DONE: begin
                    bin      <= res_bin;
                    bin_full <= res_full;
                    invalid  <= res_inv;
                    overflow <= res_ovf;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed self-checking bench for bcd_to_bin: conversions, flags, start filtering, async reset.
module tb_bcd_to_bin;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] bcd;
    logic [3:0] bin;
    logic [6:0] bin_full;
    logic       busy;
    logic       done;
    logic       invalid;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    bcd_to_bin #(.BCD_W(8), .BIN_W(4), .FULL_W(7)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .BCD      (bcd),
        .bin      (bin),
        .bin_full (bin_full),
        .busy     (busy),
        .done     (done),
        .invalid  (invalid),
        .overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int eb, input int ef, input int ei, input int eo);
        chk({tag, ".bin"},      32'(bin),      32'(eb));
        chk({tag, ".bin_full"}, 32'(bin_full), 32'(ef));
        chk({tag, ".invalid"},  32'(invalid),  32'(ei));
        chk({tag, ".overflow"}, 32'(overflow), 32'(eo));
    endtask

    task automatic convert(input string tag, input logic [7:0] v,
                           input int eb, input int ef, input int ei, input int eo);
        bcd   = v;
        start = 1'b1;
        tick;
        start = 1'b0;
        bcd   = 8'h00;
        chk({tag, ".busy_k"},  32'(busy), 1);
        chk({tag, ".done_k"},  32'(done), 0);
        tick;
        chk({tag, ".busy_k1"}, 32'(busy), 1);
        chk({tag, ".done_k1"}, 32'(done), 0);
        tick;
        chk({tag, ".done_k2"}, 32'(done), 1);
        chk({tag, ".busy_k2"}, 32'(busy), 0);
        chk_out(tag, eb, ef, ei, eo);
        tick;
        chk({tag, ".done_k3"}, 32'(done), 0);
        chk_out({tag, ".hold"}, eb, ef, ei, eo);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        bcd   = 8'h00;
        #2;
        chk("reset.busy", 32'(busy), 0);
        chk("reset.done", 32'(done), 0);
        chk_out("reset", 0, 0, 0, 0);
        tick;
        tick;
        #3;
        rst = 1'b0;
        tick;

        convert("v15", 8'h15, 15, 15, 0, 0);
        convert("v0F", 8'h0F, 0, 0, 1, 0);
        convert("vA3", 8'hA3, 0, 0, 1, 0);
        convert("v99", 8'h99, 15, 99, 0, 1);
        convert("v16", 8'h16, 15, 16, 0, 1);
        convert("v00", 8'h00, 0, 0, 0, 0);
        convert("v10", 8'h10, 10, 10, 0, 0);

        // operand change and start pulses while busy are ignored
        bcd   = 8'h07;
        start = 1'b1;
        tick;
        bcd = 8'h12;
        chk("b2b.busy_k", 32'(busy), 1);
        tick;
        chk("b2b.done_k1", 32'(done), 0);
        tick;
        chk("b2b.done_k2", 32'(done), 1);
        chk_out("b2b.first", 7, 7, 0, 0);
        tick;
        start = 1'b0;
        chk("b2b.accept_busy", 32'(busy), 1);
        chk("b2b.accept_done", 32'(done), 0);
        chk("b2b.hold_bin", 32'(bin), 7);
        tick;
        chk("b2b.second_k1", 32'(done), 0);
        tick;
        chk("b2b.second_done", 32'(done), 1);
        chk_out("b2b.second", 12, 12, 0, 0);
        tick;

        // reset in CALC aborts the conversion
        bcd   = 8'h45;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("abort.busy_pre", 32'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort.busy", 32'(busy), 0);
        chk("abort.done", 32'(done), 0);
        chk_out("abort", 0, 0, 0, 0);
        tick;
        tick;
        chk("abort.held_done", 32'(done), 0);
        #3;
        rst = 1'b0;
        tick;
        chk("abort.post_done", 32'(done), 0);
        tick;
        chk("abort.post_done2", 32'(done), 0);
        chk("abort.post_busy", 32'(busy), 0);

        convert("v09", 8'h09, 9, 9, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
